// File: rtl/csr_pkg.sv
// Shared CSR definitions for the counter unit: addresses, funct3 encodings,
// instruction field slices and the read-modify-write helper.
package csr_pkg;

    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

    localparam int ADDR_MSB = 19;
    localparam int ADDR_LSB = 8;
    localparam int ZIMM_MSB = 7;
    localparam int ZIMM_LSB = 3;
    localparam int F3_MSB   = 2;
    localparam int F3_LSB   = 0;

    typedef enum logic [2:0] {
        CSR_OP_NONE   = 3'b000,
        CSR_OP_RW     = 3'b001,
        CSR_OP_RS     = 3'b010,
        CSR_OP_RC     = 3'b011,
        CSR_OP_NONE_I = 3'b100,
        CSR_OP_RWI    = 3'b101,
        CSR_OP_RSI    = 3'b110,
        CSR_OP_RCI    = 3'b111
    } csr_op_e;

    // funct3[1:0] selects write, set-bits or clear-bits
    function automatic logic [31:0] csr_new_value(input logic [1:0]  kind,
                                                  input logic [31:0] old_val,
                                                  input logic [31:0] src_val);
        logic [31:0] res;
        case (kind)
            2'b10:   res = old_val | src_val;
            2'b11:   res = old_val & ~src_val;
            default: res = src_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counters_if.sv
// CSR access bus and retire strobe shared between the core and the counter unit.
interface csr_counters_if;

    logic        we;
    logic [19:0] instr_31_12;
    logic [31:0] wd;
    logic        retire;
    logic [31:0] rd;
    logic        hit;
    logic        illegal;

    modport master (
        output we, instr_31_12, wd, retire,
        input  rd, hit, illegal
    );

    modport slave (
        input  we, instr_31_12, wd, retire,
        output rd, hit, illegal
    );

endinterface

// File: rtl/csr_counter.sv
// One CNT_W-bit performance counter with half-word write strobes; a write
// to either half suppresses the carry that would cross into the other half.
module csr_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_en,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] value
);

    localparam int HI_W = CNT_W - 32;

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [31:0]      lo_next_s;
    logic [HI_W-1:0]  hi_next_s;

    // Next-state selection: write on one half beats the increment on that half
    always_comb begin
        cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        lo_next_s = cnt_r[31:0];
        hi_next_s = cnt_r[CNT_W-1:32];
        if (wr_lo) begin
            lo_next_s = wdata;
        end else if (wr_hi) begin
            hi_next_s = wdata[HI_W-1:0];
            if (inc_en) begin
                lo_next_s = cnt_inc_s[31:0];
            end else begin
                lo_next_s = cnt_r[31:0];
            end
        end else if (inc_en) begin
            lo_next_s = cnt_inc_s[31:0];
            hi_next_s = cnt_inc_s[CNT_W-1:32];
        end else begin
            lo_next_s = cnt_r[31:0];
            hi_next_s = cnt_r[CNT_W-1:32];
        end
    end

    // Counter register with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= {hi_next_s, lo_next_s};
        end
    end

    assign value = cnt_r;

endmodule

// File: rtl/csr_counters.sv
// Machine-mode cycle/instret counter unit with read-only user aliases.
// Optional mcountinhibit (0x320) is built when CSR_MCOUNTINHIBIT_EN is defined.
module csr_counters
    import csr_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    csr_counters_if.slave bus
);

    logic [11:0]      addr_s;
    logic [4:0]       zimm_s;
    logic [2:0]       f3_s;
    csr_op_e          op_s;
    logic             op_valid_s;
    logic             op_set_clr_s;
    logic [31:0]      src_s;
    logic [31:0]      old_s;
    logic [31:0]      new_s;
    logic             addr_hit_s;
    logic             hit_s;
    logic             read_only_s;
    logic             no_write_s;
    logic             wr_en_s;
    logic             illegal_s;
    logic [CNT_W-1:0] mcycle_s;
    logic [CNT_W-1:0] minstret_s;
    logic [31:0]      mcycle_hi_s;
    logic [31:0]      minstret_hi_s;
    logic             cy_inh_s;
    logic             ir_inh_s;
    logic             cyc_inc_s;
    logic             ins_inc_s;

    // Instruction field decode and operand selection
    always_comb begin
        addr_s = bus.instr_31_12[ADDR_MSB:ADDR_LSB];
        zimm_s = bus.instr_31_12[ZIMM_MSB:ZIMM_LSB];
        f3_s   = bus.instr_31_12[F3_MSB:F3_LSB];
        op_s   = csr_op_e'(f3_s);
        case (op_s)
            CSR_OP_RW, CSR_OP_RWI: begin
                op_valid_s   = 1'b1;
                op_set_clr_s = 1'b0;
            end
            CSR_OP_RS, CSR_OP_RSI, CSR_OP_RC, CSR_OP_RCI: begin
                op_valid_s   = 1'b1;
                op_set_clr_s = 1'b1;
            end
            default: begin
                op_valid_s   = 1'b0;
                op_set_clr_s = 1'b0;
            end
        endcase
        if (f3_s[2]) begin
            src_s = {27'd0, zimm_s};
        end else begin
            src_s = bus.wd;
        end
    end

    // High halves are zero-extended when CNT_W is below 64
    always_comb begin
        mcycle_hi_s                  = 32'd0;
        minstret_hi_s                = 32'd0;
        mcycle_hi_s[CNT_W-33:0]      = mcycle_s[CNT_W-1:32];
        minstret_hi_s[CNT_W-33:0]    = minstret_s[CNT_W-1:32];
    end

    // Address decode and old-value read mux
    always_comb begin
        addr_hit_s = 1'b1;
        old_s      = 32'd0;
        case (addr_s)
            CSR_MCYCLE, CSR_CYCLE:       old_s = mcycle_s[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:     old_s = mcycle_hi_s;
            CSR_MINSTRET, CSR_INSTRET:   old_s = minstret_s[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: old_s = minstret_hi_s;
`ifdef CSR_MCOUNTINHIBIT_EN
            CSR_MCOUNTINHIBIT:           old_s = {29'd0, ir_inh_s, 1'b0, cy_inh_s};
`endif
            default: begin
                addr_hit_s = 1'b0;
                old_s      = 32'd0;
            end
        endcase
    end

    // Write qualification: RS/RC with a zero rs1/zimm field never writes
    always_comb begin
        new_s       = csr_new_value(f3_s[1:0], old_s, src_s);
        hit_s       = op_valid_s & addr_hit_s;
        read_only_s = (addr_s[11:10] == 2'b11);
        no_write_s  = op_set_clr_s & (zimm_s == 5'd0);
        wr_en_s     = bus.we & hit_s & ~no_write_s & ~read_only_s;
        illegal_s   = bus.we & hit_s & read_only_s & ~no_write_s;
    end

    assign bus.rd      = hit_s ? old_s : 32'd0;
    assign bus.hit     = hit_s;
    assign bus.illegal = illegal_s;

`ifdef CSR_MCOUNTINHIBIT_EN
    logic cy_inh_r;
    logic ir_inh_r;

    // mcountinhibit: only CY (bit 0) and IR (bit 2) are stored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cy_inh_r <= 1'b0;
            ir_inh_r <= 1'b0;
        end else if (wr_en_s && (addr_s == CSR_MCOUNTINHIBIT)) begin
            cy_inh_r <= new_s[0];
            ir_inh_r <= new_s[2];
        end else begin
            cy_inh_r <= cy_inh_r;
            ir_inh_r <= ir_inh_r;
        end
    end

    assign cy_inh_s = cy_inh_r;
    assign ir_inh_s = ir_inh_r;
`else
    assign cy_inh_s = 1'b0;
    assign ir_inh_s = 1'b0;
`endif

    assign cyc_inc_s = ~cy_inh_s;
    assign ins_inc_s = bus.retire & ~ir_inh_s;

    csr_counter #(.CNT_W(CNT_W)) u_mcycle (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (cyc_inc_s),
        .wr_lo  (wr_en_s && (addr_s == CSR_MCYCLE)),
        .wr_hi  (wr_en_s && (addr_s == CSR_MCYCLEH)),
        .wdata  (new_s),
        .value  (mcycle_s)
    );

    csr_counter #(.CNT_W(CNT_W)) u_minstret (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (ins_inc_s),
        .wr_lo  (wr_en_s && (addr_s == CSR_MINSTRET)),
        .wr_hi  (wr_en_s && (addr_s == CSR_MINSTRETH)),
        .wdata  (new_s),
        .value  (minstret_s)
    );

endmodule
